// File: rtl/led_pkg.sv
// Shared LED-strip definitions: transmitter state encoding and default one-wire timing.
// Also used by the frame writer.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    BIT_HI,
    BIT_LO,
    LATCH
  } led_state_t;

  localparam int DEF_FRAME_WORDS  = 35;
  localparam int DEF_T0H          = 2;
  localparam int DEF_T0L          = 6;
  localparam int DEF_T1H          = 5;
  localparam int DEF_T1L          = 3;
  localparam int DEF_RESET_CYC    = 400;
  localparam int DEF_UNDERRUN_CYC = 200;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Interval timer: load a cycle count, count down, and raise done during the last cycle.
// A load on the done cycle starts the next interval back-to-back.
module led_bit_timer #(
  parameter int W = 9
) (
  input  logic         clk_slow,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] cycles,
  output logic         done
);

  logic [W-1:0] count_reg;
  logic         running_reg;

  always_ff @(posedge clk_slow) begin
    if (!rstn) begin
      count_reg   <= '0;
      running_reg <= 1'b0;
    end else if (load) begin
      count_reg   <= cycles - W'(1);
      running_reg <= 1'b1;
    end else if (running_reg) begin
      if (count_reg == '0) begin
        running_reg <= 1'b0;
      end else begin
        count_reg <= count_reg - W'(1);
      end
    end
  end

  assign done = running_reg && (count_reg == '0);

endmodule

// File: rtl/led_frame_tx.sv
// One-wire LED frame transmitter: pulls 12-bit words from a first-word-fall-through FIFO,
// sends them MSB first as pulse-width-coded bits, then holds the line low to latch.
module led_frame_tx
  import led_pkg::*;
#(
  parameter int FRAME_WORDS  = DEF_FRAME_WORDS,
  parameter int T0H          = DEF_T0H,
  parameter int T0L          = DEF_T0L,
  parameter int T1H          = DEF_T1H,
  parameter int T1L          = DEF_T1L,
  parameter int RESET_CYC    = DEF_RESET_CYC,
  parameter int UNDERRUN_CYC = DEF_UNDERRUN_CYC
) (
  input  logic        clk_slow,
  input  logic        rstn,
  input  logic        send_start,
  input  logic        valid,
  input  logic [11:0] dout,
  input  logic        empty_flag,
  output logic        re,
  output logic        led_out,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int TW = $clog2(max2(max2(RESET_CYC, UNDERRUN_CYC),
                                  max2(max2(T0H, T0L), max2(T1H, T1L))) + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  led_state_t    state_reg;
  logic          start_prev_reg;
  logic          start_armed_reg;
  logic [WW-1:0] word_cnt_reg;
  logic [3:0]    bit_cnt_reg;
  logic [11:0]   shift_reg;
  logic [TW-1:0] wait_cnt_reg;

  logic          tmr_load;
  logic [TW-1:0] tmr_cycles;
  logic          tmr_done;
  logic          start_edge;
  logic          last_word;
  logic          underrun_hit;
  logic          unused_status;

  // empty_flag is status only; valid alone governs every FIFO decision.
  assign unused_status = empty_flag;

  // A level held high through reset must fall once before it can start a frame.
  assign start_edge   = send_start && !start_prev_reg && start_armed_reg;
  assign last_word    = (word_cnt_reg == WW'(1));
  assign underrun_hit = (wait_cnt_reg == TW'(UNDERRUN_CYC - 1));
  assign re           = rstn && (state_reg == FETCH) && valid;

  always_comb begin
    tmr_load   = 1'b0;
    tmr_cycles = '0;
    case (state_reg)
      FETCH: begin
        if (valid) begin
          tmr_load   = 1'b1;
          tmr_cycles = dout[11] ? TW'(T1H) : TW'(T0H);
        end else if (underrun_hit) begin
          tmr_load   = 1'b1;
          tmr_cycles = TW'(RESET_CYC);
        end
      end
      BIT_HI: begin
        if (tmr_done) begin
          tmr_load   = 1'b1;
          tmr_cycles = shift_reg[11] ? TW'(T1L) : TW'(T0L);
        end
      end
      BIT_LO: begin
        if (tmr_done) begin
          if (bit_cnt_reg != 4'd0) begin
            tmr_load   = 1'b1;
            tmr_cycles = shift_reg[10] ? TW'(T1H) : TW'(T0H);
          end else if (last_word) begin
            tmr_load   = 1'b1;
            tmr_cycles = TW'(RESET_CYC);
          end
        end
      end
      default: ;
    endcase
  end

  led_bit_timer #(.W(TW)) bit_timer (
    .clk_slow (clk_slow),
    .rstn     (rstn),
    .load     (tmr_load),
    .cycles   (tmr_cycles),
    .done     (tmr_done)
  );

  always_ff @(posedge clk_slow) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      start_prev_reg  <= 1'b0;
      start_armed_reg <= 1'b0;
      word_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      wait_cnt_reg    <= '0;
      led_out         <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      start_prev_reg <= send_start;
      if (!send_start) begin
        start_armed_reg <= 1'b1;
      end
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_edge) begin
            state_reg    <= FETCH;
            word_cnt_reg <= WW'(FRAME_WORDS);
            wait_cnt_reg <= '0;
            underrun     <= 1'b0;
            busy         <= 1'b1;
          end
        end
        FETCH: begin
          if (valid) begin
            shift_reg    <= dout;
            bit_cnt_reg  <= 4'd11;
            wait_cnt_reg <= '0;
            led_out      <= 1'b1;
            state_reg    <= BIT_HI;
          end else if (underrun_hit) begin
            wait_cnt_reg <= '0;
            underrun     <= 1'b1;
            state_reg    <= LATCH;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
          end
        end
        BIT_HI: begin
          if (tmr_done) begin
            led_out   <= 1'b0;
            state_reg <= BIT_LO;
          end
        end
        BIT_LO: begin
          if (tmr_done) begin
            shift_reg <= {shift_reg[10:0], 1'b0};
            if (bit_cnt_reg != 4'd0) begin
              bit_cnt_reg <= bit_cnt_reg - 4'd1;
              led_out     <= 1'b1;
              state_reg   <= BIT_HI;
            end else begin
              word_cnt_reg <= word_cnt_reg - WW'(1);
              state_reg    <= last_word ? LATCH : FETCH;
            end
          end
        end
        LATCH: begin
          if (tmr_done) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_frame_tx.md
LED_FRAME_TX -- requirements
Module: led_frame_tx

Interface
REQ-001 Parameter FRAME_WORDS, default 35: number of 12-bit words per LED frame.
REQ-002 Parameter T0H, default 2: clk_slow cycles line is high for a '0' bit.
REQ-003 Parameter T0L, default 6: clk_slow cycles line is low for a '0' bit.
REQ-004 Parameter T1H, default 5: clk_slow cycles line is high for a '1' bit.
REQ-005 Parameter T1L, default 3: clk_slow cycles line is low for a '1' bit.
REQ-006 Parameter RESET_CYC, default 400: low cycles closing a frame (latch).
REQ-007 Parameter UNDERRUN_CYC, default 200: maximum FIFO wait per word before abort.
REQ-008 clk_slow  in  1  sole clock; all logic on its rising edge.
REQ-009 rstn  in  1  reset, synchronous, active-low.
REQ-010 send_start  in  1  frame request, already synchronised to clk_slow; level.
REQ-011 valid  in  1  FIFO read side: dout holds a valid word (first-word-fall-through).
REQ-012 dout  in  12  FIFO head word, {R[3:0],G[3:0],B[3:0]}.
REQ-013 empty_flag  in  1  FIFO empty; informational, used only for status.
REQ-014 re  out  1  FIFO pop, one-cycle pulse per consumed word.
REQ-015 led_out  out  1  one-wire LED data line.
REQ-016 busy  out  1  high from frame acceptance until latch completes.
REQ-017 frame_done  out  1  one-cycle pulse at end of latch.
REQ-018 underrun  out  1  sticky; set on FIFO starvation abort, cleared on next accepted frame.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, BIT_HI, BIT_LO, LATCH.
REQ-020 IDLE: frame accepted on rising edge of send_start (send_start=1, registered previous=0); go FETCH, load word counter with FRAME_WORDS, clear underrun, busy=1.
REQ-021 send_start edges while busy SHALL be ignored (not queued).
REQ-022 FETCH: if valid=1, assert re for exactly that cycle, capture dout into 12-bit shift register, load bit counter 11, go BIT_HI next cycle.
REQ-023 FETCH with valid=0: led_out=0, wait counter increments; on reaching UNDERRUN_CYC set underrun, go LATCH.
REQ-024 BIT_HI: led_out=1 for T1H cycles if shift MSB=1 else T0H cycles, then BIT_LO.
REQ-025 BIT_LO: led_out=0 for T1L or T0L cycles; then shift left one; if bits remain go BIT_HI, else decrement word counter.
REQ-026 After last bit of a word: if word counter nonzero go FETCH, else go LATCH.
REQ-027 Bits SHALL be sent MSB first (dout[11] first); bit period T0H+T0L=T1H+T1L=8 cycles at defaults.
REQ-028 FETCH-to-first-high latency SHALL be 1 cycle when valid=1 on entry; back-to-back words therefore insert 1 low cycle between words, absorbed as line low.
REQ-029 LATCH: led_out=0 for RESET_CYC cycles; on final cycle pulse frame_done, deassert busy, go IDLE.
REQ-030 re SHALL never assert when valid=0 or outside FETCH.
REQ-031 Timing counters SHALL be sized for max(RESET_CYC, UNDERRUN_CYC) without wrap; word counter for FRAME_WORDS.
REQ-032 Words left in FIFO after an underrun abort are not flushed; next frame consumes from head.

Reset
REQ-033 rstn=0 at any rising edge, including mid-frame: state IDLE, led_out=0, re=0, busy=0, frame_done=0, underrun=0, all counters and shift register 0, send_start edge register 0.
REQ-034 A send_start held high through reset release SHALL NOT start a frame until it falls and rises again.

Structure
REQ-035 State enum and default timing constants SHALL live in shared package led_pkg, reused by the frame writer.
REQ-036 Bit timing generation SHALL be a sub-module led_bit_timer (load cycles, count down, done pulse); no other sub-modules.

Verification
REQ-037 Reset, send_start rising, FIFO preloaded 35 words 0xFFF -> 420 '1' bits each 5 high/3 low, 35 re pulses, 400 low cycles, one frame_done.
REQ-038 Single word 0xA5C, FRAME_WORDS=1 -> line pattern 1,0,1,0,0,1,0,1,1,1,0,0 with correct high widths, then latch.
REQ-039 FIFO holds 10 of 35 words, valid stays 0 -> 200 cycles after word 10 underrun=1, LATCH 400 cycles, frame_done, busy=0.
REQ-040 send_start toggled mid-frame -> no effect; exactly 35 re pulses in the frame.
REQ-041 rstn=0 during word 5 bit 3 -> next edge led_out=0, busy=0, re=0; new send_start edge restarts cleanly.
REQ-042 valid dropped 3 cycles between words -> line low 3 extra cycles, no underrun, no re while valid=0.
